// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MIPS memory stage: memory-op codes, exception codes,
// FSM states and small op-classification helpers.
package mem_access_unit_pkg;

  typedef enum logic [3:0] {
    MEM_OP_NONE = 4'd0,
    MEM_OP_LB   = 4'd1,
    MEM_OP_LBU  = 4'd2,
    MEM_OP_LH   = 4'd3,
    MEM_OP_LHU  = 4'd4,
    MEM_OP_LW   = 4'd5,
    MEM_OP_SB   = 4'd6,
    MEM_OP_SH   = 4'd7,
    MEM_OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    EXC_NONE   = 2'b00,
    EXC_ADEL   = 2'b01,
    EXC_ADES   = 2'b10,
    EXC_BUSERR = 2'b11
  } exc_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Unknown op codes collapse to NONE so they behave as a pass-through.
  function automatic mem_op_e decode_op(input logic [3:0] code);
    mem_op_e op;
    case (code)
      4'd1:    op = MEM_OP_LB;
      4'd2:    op = MEM_OP_LBU;
      4'd3:    op = MEM_OP_LH;
      4'd4:    op = MEM_OP_LHU;
      4'd5:    op = MEM_OP_LW;
      4'd6:    op = MEM_OP_SB;
      4'd7:    op = MEM_OP_SH;
      4'd8:    op = MEM_OP_SW;
      default: op = MEM_OP_NONE;
    endcase
    return op;
  endfunction

  function automatic logic is_load(input mem_op_e op);
    return (op == MEM_OP_LB) || (op == MEM_OP_LBU) || (op == MEM_OP_LH) ||
           (op == MEM_OP_LHU) || (op == MEM_OP_LW);
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
  endfunction

  function automatic logic misaligned(input mem_op_e op, input logic [1:0] addr_lo);
    logic bad;
    case (op)
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: bad = addr_lo[0];
      MEM_OP_LW, MEM_OP_SW:             bad = (addr_lo != 2'b00);
      default:                          bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load extraction: picks the addressed byte/halfword out of a little-endian
// read word and sign- or zero-extends it to 32 bits.
module mem_access_unit_load_align
  import mem_access_unit_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = rdata[7:0];
    case (addr_lo)
      2'd0: lane_byte = rdata[7:0];
      2'd1: lane_byte = rdata[15:8];
      2'd2: lane_byte = rdata[23:16];
      2'd3: lane_byte = rdata[31:24];
      default: lane_byte = rdata[7:0];
    endcase
    lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    data = '0;
    case (op)
      MEM_OP_LB:  data = {{24{lane_byte[7]}}, lane_byte};
      MEM_OP_LBU: data = {24'd0, lane_byte};
      MEM_OP_LH:  data = {{16{lane_half[15]}}, lane_half};
      MEM_OP_LHU: data = {16'd0, lane_half};
      MEM_OP_LW:  data = rdata;
      default:    data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MIPS memory stage: runs one load/store per request on a wait-stated bus and
// returns one registered result (data or exception) to writeback.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_mem_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_exc,
  output logic [31:0] out_badvaddr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata
);

  // The counter value seen on the last waiting cycle before the bus is abandoned.
  localparam int              TO_LIM  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LIM);

  state_e            state;
  mem_op_e           op_q;
  logic [31:0]       addr_q;
  logic [CNT_W-1:0]  cnt;
  mem_op_e           in_op;
  logic [31:0]       load_data;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;

  assign in_op    = decode_op(in_mem_op);
  assign in_ready = (state == ST_IDLE);

  mem_access_unit_load_align u_load_align (
    .op      (op_q),
    .addr_lo (addr_q[1:0]),
    .rdata   (dmem_rdata),
    .data    (load_data)
  );

  // Lane placement for stores; loads always fetch the whole word.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = '0;
    case (in_op)
      MEM_OP_SB: begin
        st_be    = 4'b0001 << in_addr[1:0];
        st_wdata = {4{in_wdata[7:0]}};
      end
      MEM_OP_SH: begin
        st_be    = in_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{in_wdata[15:0]}};
      end
      MEM_OP_SW: begin
        st_be    = 4'b1111;
        st_wdata = in_wdata;
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      op_q         <= MEM_OP_NONE;
      addr_q       <= '0;
      cnt          <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_exc      <= EXC_NONE;
      out_badvaddr <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q   <= in_op;
            addr_q <= in_addr;
            cnt    <= '0;
            if (in_op == MEM_OP_NONE) begin
              state        <= ST_RESP;
              out_valid    <= 1'b1;
              out_data     <= in_addr;
              out_exc      <= EXC_NONE;
              out_badvaddr <= '0;
            end else if (misaligned(in_op, in_addr[1:0])) begin
              state        <= ST_RESP;
              out_valid    <= 1'b1;
              out_data     <= '0;
              out_exc      <= is_store(in_op) ? EXC_ADES : EXC_ADEL;
              out_badvaddr <= in_addr;
            end else begin
              state      <= ST_BUS;
              dmem_req   <= 1'b1;
              dmem_we    <= is_store(in_op);
              dmem_addr  <= {in_addr[31:2], 2'b00};
              dmem_be    <= st_be;
              dmem_wdata <= st_wdata;
            end
          end
        end

        // A ready arriving on the timeout cycle still completes the access.
        ST_BUS: begin
          if (dmem_ready) begin
            state        <= ST_RESP;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= '0;
            dmem_wdata   <= '0;
            out_valid    <= 1'b1;
            out_data     <= is_load(op_q) ? load_data : '0;
            out_exc      <= EXC_NONE;
            out_badvaddr <= '0;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt == TO_LAST)) begin
            state        <= ST_RESP;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= '0;
            dmem_wdata   <= '0;
            out_valid    <= 1'b1;
            out_data     <= '0;
            out_exc      <= EXC_BUSERR;
            out_badvaddr <= addr_q;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_RESP: begin
          if (out_ready) begin
            state        <= ST_IDLE;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_exc      <= EXC_NONE;
            out_badvaddr <= '0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a scripted wait-state bus
// and TIMEOUT_CYCLES = 4.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_mem_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_exc;
  logic [31:0] out_badvaddr;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  int compared   = 0;
  int mismatched = 0;

  int          obs_lat;
  int          obs_req;
  logic [31:0] cap_addr;
  logic [3:0]  cap_be;
  logic        cap_we;
  logic [31:0] cap_wdata;
  logic [31:0] obs_data;
  logic [1:0]  obs_exc;
  logic [31:0] obs_bad;
  logic        obs_stable;
  logic        obs_after_valid;
  logic        obs_after_ready;

  mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mem_op    (in_mem_op),
    .in_addr      (in_addr),
    .in_wdata     (in_wdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_exc      (out_exc),
    .out_badvaddr (out_badvaddr),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_ready   (dmem_ready),
    .dmem_rdata   (dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request, plays the bus (ready after 'waits' request cycles, never if
  // negative), holds out_ready low for 'hold' cycles, then completes the handshake.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input int waits, input int hold);
    int bus_cnt;
    int guard;
    @(negedge clk);
    checkOutput("in_ready_before", 32'(in_ready), 32'd1);
    in_valid   = 1'b1;
    in_mem_op  = op;
    in_addr    = addr;
    in_wdata   = wdata;
    dmem_rdata = rdata;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_mem_op = 4'd0;
    in_addr   = 32'd0;
    in_wdata  = 32'd0;
    obs_lat   = 1;
    obs_req   = 0;
    bus_cnt   = 0;
    guard     = 0;
    cap_addr  = '0;
    cap_be    = '0;
    cap_we    = 1'b0;
    cap_wdata = '0;
    while (!out_valid && guard < 50) begin
      if (dmem_req) begin
        obs_req++;
        cap_addr   = dmem_addr;
        cap_be     = dmem_be;
        cap_we     = dmem_we;
        cap_wdata  = dmem_wdata;
        dmem_ready = (waits >= 0) && (bus_cnt == waits);
        bus_cnt++;
      end
      @(posedge clk);
      #1;
      dmem_ready = 1'b0;
      obs_lat++;
      guard++;
    end
    checkOutput("resp_within_bound", 32'(out_valid), 32'd1);
    obs_data   = out_data;
    obs_exc    = out_exc;
    obs_bad    = out_badvaddr;
    obs_stable = 1'b1;
    repeat (hold) begin
      @(posedge clk);
      #1;
      if (out_data !== obs_data || out_valid !== 1'b1 || in_ready !== 1'b0)
        obs_stable = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready       = 1'b0;
    obs_after_valid = out_valid;
    obs_after_ready = in_ready;
  endtask

  task automatic run_vec(input string name, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int waits, input int hold,
                         input logic [31:0] exp_data, input logic [1:0] exp_exc,
                         input logic [31:0] exp_bad, input int exp_lat, input int exp_req,
                         input logic exp_we, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata);
    applyStimulus(op, addr, wdata, rdata, waits, hold);
    checkOutput({name, ".data"},     obs_data, exp_data);
    checkOutput({name, ".exc"},      32'(obs_exc), 32'(exp_exc));
    checkOutput({name, ".badvaddr"}, obs_bad, exp_bad);
    checkOutput({name, ".latency"},  32'(obs_lat), 32'(exp_lat));
    checkOutput({name, ".req_cyc"},  32'(obs_req), 32'(exp_req));
    if (exp_req > 0) begin
      checkOutput({name, ".dmem_addr"}, cap_addr, {addr[31:2], 2'b00});
      checkOutput({name, ".dmem_we"},   32'(cap_we), 32'(exp_we));
      checkOutput({name, ".dmem_be"},   32'(cap_be), 32'(exp_be));
      if (exp_we)
        checkOutput({name, ".dmem_wdata"}, cap_wdata, exp_wdata);
    end
    if (hold > 0)
      checkOutput({name, ".held_stable"}, 32'(obs_stable), 32'd1);
    checkOutput({name, ".valid_after_hs"}, 32'(obs_after_valid), 32'd0);
    checkOutput({name, ".ready_after_hs"}, 32'(obs_after_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_mem_op  = 4'd0;
    in_addr    = 32'd0;
    in_wdata   = 32'd0;
    out_ready  = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst.in_ready",  32'(in_ready), 32'd1);
    checkOutput("rst.dmem_req",  32'(dmem_req), 32'd0);
    checkOutput("rst.out_data",  out_data, 32'd0);
    checkOutput("rst.dmem_be",   32'(dmem_be), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //       name     op           addr          wdata         rdata        wt hd  data          exc    bad           lat req we  be       wdata
    run_vec("lb",    MEM_OP_LB,   32'h0000_1003, 32'h0,        32'h80FF_1234, 2, 0, 32'hFFFF_FF80, 2'b00, 32'h0,        4, 3, 1'b0, 4'b1111, 32'h0);
    run_vec("sh",    MEM_OP_SH,   32'h0000_2002, 32'h0000_BEEF, 32'h0,       0, 0, 32'h0,        2'b00, 32'h0,        2, 1, 1'b1, 4'b1100, 32'hBEEF_BEEF);
    run_vec("lw_ad", MEM_OP_LW,   32'h0000_0006, 32'h0,        32'h0,        0, 0, 32'h0,        2'b01, 32'h0000_0006, 1, 0, 1'b0, 4'b0000, 32'h0);
    run_vec("sw_ad", MEM_OP_SW,   32'h0000_0005, 32'h1111_2222, 32'h0,       0, 0, 32'h0,        2'b10, 32'h0000_0005, 1, 0, 1'b0, 4'b0000, 32'h0);
    run_vec("none",  MEM_OP_NONE, 32'h1234_5678, 32'h0,        32'h0,        0, 3, 32'h1234_5678, 2'b00, 32'h0,       1, 0, 1'b0, 4'b0000, 32'h0);
    run_vec("tmo",   MEM_OP_LW,   32'h0000_4000, 32'h0,        32'h0,       -1, 0, 32'h0,        2'b11, 32'h0000_4000, 5, 4, 1'b0, 4'b1111, 32'h0);
    run_vec("lh",    MEM_OP_LH,   32'h0000_0010, 32'h0,        32'h1234_8001, 1, 0, 32'hFFFF_8001, 2'b00, 32'h0,      3, 2, 1'b0, 4'b1111, 32'h0);
    run_vec("lhu",   MEM_OP_LHU,  32'h0000_0012, 32'h0,        32'h8001_7FFF, 0, 0, 32'h0000_8001, 2'b00, 32'h0,      2, 1, 1'b0, 4'b1111, 32'h0);
    run_vec("sb",    MEM_OP_SB,   32'h0000_0007, 32'h1234_56AB, 32'h0,       0, 0, 32'h0,        2'b00, 32'h0,        2, 1, 1'b1, 4'b1000, 32'hABAB_ABAB);
    run_vec("sh_lo", MEM_OP_SH,   32'h0000_2000, 32'hFFFF_1357, 32'h0,       0, 0, 32'h0,        2'b00, 32'h0,        2, 1, 1'b1, 4'b0011, 32'h1357_1357);
    run_vec("lw",    MEM_OP_LW,   32'h0000_0008, 32'h0,        32'hDEAD_BEEF, 3, 0, 32'hDEAD_BEEF, 2'b00, 32'h0,      5, 4, 1'b0, 4'b1111, 32'h0);
    run_vec("lbu",   MEM_OP_LBU,  32'h0000_1001, 32'h0,        32'h0000_F000, 0, 0, 32'h0000_00F0, 2'b00, 32'h0,      2, 1, 1'b0, 4'b1111, 32'h0);
    run_vec("unk",   4'hF,        32'hCAFE_0001, 32'h0,        32'h0,        0, 0, 32'hCAFE_0001, 2'b00, 32'h0,       1, 0, 1'b0, 4'b0000, 32'h0);
    run_vec("lh_ad", MEM_OP_LH,   32'h0000_0003, 32'h0,        32'h0,        0, 0, 32'h0,        2'b01, 32'h0000_0003, 1, 0, 1'b0, 4'b0000, 32'h0);

    // Reset in the middle of a bus access.
    @(negedge clk);
    in_valid  = 1'b1;
    in_mem_op = MEM_OP_LW;
    in_addr   = 32'h0000_5000;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_mem_op = 4'd0;
    in_addr   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midrst.req_before", 32'(dmem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst.req_async",   32'(dmem_req), 32'd0);
    checkOutput("midrst.valid_async", 32'(out_valid), 32'd0);
    checkOutput("midrst.in_ready",    32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("lbu_rst", MEM_OP_LBU, 32'h0000_3002, 32'h0, 32'h119A_2233, 0, 0, 32'h0000_009A, 2'b00, 32'h0, 2, 1, 1'b0, 4'b1111, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
